// File: rtl/servo_bank.sv
// servo_bank: N_CH servo PWM channels sharing one frame counter, ramped per frame.
// Define SERVO_BANK_STATUS_EN to build the sel mux and the data_out status register.
module servo_bank #(
  parameter int N_CH        = 4,
  parameter int FRAME_TICKS = 20000,
  parameter int CNT_W       = 15,
  parameter int PW_MIN      = 1000,
  parameter int PW_MAX      = 2200,
  parameter int PW_STEP     = 10
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   toggle,
  input  logic [N_CH-1:0]   freeze,
  input  logic [1:0]        sel,
  output logic [N_CH-1:0]   pwm_out,
  output logic [8*N_CH-1:0] pos,
  output logic              frame_tick,
  output logic [CNT_W-1:0]  counter,
  output logic [15:0]       data_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_TICKS - 1);
  localparam logic [15:0] PMIN  = 16'(PW_MIN);
  localparam logic [15:0] PMAX  = 16'(PW_MAX);
  localparam logic [15:0] PSTEP = 16'(PW_STEP);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pw_q  [N_CH];
  logic [15:0]      pw_d  [N_CH];
  logic [7:0]       pos_q [N_CH];
  logic [7:0]       pos_d [N_CH];
  logic [N_CH-1:0]  pwm_q, pwm_d;
  logic             ft_q;
  logic             boundary;

  assign boundary = (cnt_q == LAST);
  assign cnt_d    = boundary ? '0 : cnt_q + 1'b1;

  // Direction inputs are only looked at on the boundary cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      pw_d[i]  = pw_q[i];
      pos_d[i] = pos_q[i];
      pwm_d[i] = 32'(cnt_q) < 32'(pw_q[i]);
      if (boundary && !freeze[i]) begin
        if (toggle[i] && pw_q[i] < PMAX) begin
          pw_d[i]  = pw_q[i] + PSTEP;
          pos_d[i] = pos_q[i] + 8'd1;
        end else if (!toggle[i] && pw_q[i] > PMIN) begin
          pw_d[i]  = pw_q[i] - PSTEP;
          pos_d[i] = pos_q[i] - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pwm_q <= '0;
      ft_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        pw_q[i]  <= PMIN;
        pos_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      pwm_q <= pwm_d;
      ft_q  <= boundary;
      pw_q  <= pw_d;
      pos_q <= pos_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign frame_tick = ft_q;
  assign counter    = cnt_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_pos
    assign pos[8*g +: 8] = pos_q[g];
  end

`ifdef SERVO_BANK_STATUS_EN
  logic [1:0]  csel;
  logic [7:0]  spos;
  logic        stg, sfz;
  logic [15:0] dout_q, dout_d;

  // Snapshot uses post-update position of the selected channel.
  always_comb begin
    csel = (32'(sel) < N_CH) ? sel : 2'd0;
    spos = '0;
    stg  = 1'b0;
    sfz  = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (csel == 2'(i)) begin
        spos = pos_d[i];
        stg  = toggle[i];
        sfz  = freeze[i];
      end
    end
    dout_d = dout_q;
    if (boundary)
      dout_d = {2'b01, csel, spos[7:4], 2'b00, spos[3:0], stg, sfz};
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign data_out = dout_q;
`else
  logic [1:0] unused_sel;
  assign unused_sel = sel;
  assign data_out   = '0;
`endif

endmodule

// File: tb/tb_servo_bank.sv
// tb_servo_bank: scoreboard bench for servo_bank with scaled frame timing.
// A second N_CH=2 instance covers out-of-range sel reporting channel 0.
module tb_servo_bank;

  localparam int N    = 4;
  localparam int FT   = 300;
  localparam int CW   = 9;
  localparam int MIN  = 10;
  localparam int STEP = 2;
  localparam int K    = 120;
  localparam int MAX  = MIN + K * STEP;
  localparam int HALF = FT / 2;

  logic          mclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    toggle = '0;
  logic [3:0]    freeze = '0;
  logic [1:0]    sel = '0;
  logic [3:0]    pwm_out;
  logic [31:0]   pos;
  logic          frame_tick;
  logic [CW-1:0] counter;
  logic [15:0]   data_out;
  logic [1:0]    pwm2;
  logic [15:0]   pos2;
  logic          ft2;
  logic [CW-1:0] cnt2;
  logic [15:0]   dout2;

  servo_bank #(
    .N_CH(N), .FRAME_TICKS(FT), .CNT_W(CW),
    .PW_MIN(MIN), .PW_MAX(MAX), .PW_STEP(STEP)
  ) dut (
    .mclk(mclk), .rst_n(rst_n),
    .toggle(toggle), .freeze(freeze), .sel(sel),
    .pwm_out(pwm_out), .pos(pos), .frame_tick(frame_tick),
    .counter(counter), .data_out(data_out)
  );

  servo_bank #(
    .N_CH(2), .FRAME_TICKS(FT), .CNT_W(CW),
    .PW_MIN(MIN), .PW_MAX(MAX), .PW_STEP(STEP)
  ) dut2 (
    .mclk(mclk), .rst_n(rst_n),
    .toggle(toggle[1:0]), .freeze(freeze[1:0]), .sel(sel),
    .pwm_out(pwm2), .pos(pos2), .frame_tick(ft2),
    .counter(cnt2), .data_out(dout2)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [31:0] p;
    logic [15:0] d;
    logic [15:0] d2;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   mpos[4];
  int   cur[4];
  int   hc[4];
  int   hc2[2];
  int   ctr_m = 0;
  int   now_c = 0;
  bit   mon_en = 0;
  bit   seen = 0;
  bit   bnd = 0;
  logic [15:0] last_d = '0;
  logic [15:0] last_d2 = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic mon();
    exp_t e;
    now_c = ctr_m;
    chk("cnt", 32'(counter), 32'(ctr_m));
    chk("cnt2", 32'(cnt2), 32'(ctr_m));
    if (ctr_m <= 1) begin
      chk("ftick", 32'(frame_tick), 32'(ctr_m == 0 && seen));
      chk("ftick2", 32'(ft2), 32'(ctr_m == 0 && seen));
    end
    if (ctr_m == 0) begin
      hc  = '{0, 0, 0, 0};
      hc2 = '{0, 0};
    end
    for (int i = 0; i < 4; i++) hc[i] += int'(pwm_out[i]);
    for (int i = 0; i < 2; i++) hc2[i] += int'(pwm2[i]);
    if (ctr_m == FT - 1) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("pw%0d", i), 32'(hc[i]), 32'(MIN + cur[i] * STEP));
      for (int i = 0; i < 2; i++)
        chk($sformatf("pw2_%0d", i), 32'(hc2[i]), 32'(MIN + cur[i] * STEP));
      chk("dout_hold", 32'(data_out), 32'(last_d));
      chk("dout2_hold", 32'(dout2), 32'(last_d2));
      bnd  = 1;
      seen = 1;
    end
    if (ctr_m == 1 && bnd) begin
      bnd = 0;
      chk("sb_depth", 32'(sbq.size()), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pos", pos, e.p);
        chk("pos2", 32'(pos2), 32'(e.p[15:0]));
        chk("dout", 32'(data_out), 32'(e.d));
        chk("dout2", 32'(dout2), 32'(e.d2));
        for (int i = 0; i < 4; i++) cur[i] = int'(e.p[8*i +: 8]);
        last_d  = e.d;
        last_d2 = e.d2;
      end
    end
    ctr_m = (ctr_m == FT - 1) ? 0 : ctr_m + 1;
  endtask

  task automatic step();
    @(negedge mclk);
    if (mon_en) mon();
  endtask

  task automatic wait_c(input int t);
    int g = 0;
    do begin
      step();
      g++;
    end while (now_c != t && g < 2 * FT);
    if (now_c != t) chk("wait_timeout", 32'(now_c), 32'(t));
  endtask

  function automatic logic [15:0] stat(input int c, input logic [3:0] tg,
                                       input logic [3:0] fz);
    logic [7:0] p;
    logic [1:0] cc;
    p  = 8'(mpos[c]);
    cc = 2'(c);
`ifdef SERVO_BANK_STATUS_EN
    return {2'b01, cc, p[7:4], 2'b00, p[3:0], tg[c], fz[c]};
`else
    return (p == 8'hxx || cc == 2'bxx) ? 16'hxxxx : 16'h0000;
`endif
  endfunction

  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    mon_en = 0;
    toggle = '0;
    freeze = '0;
    step();
    chk("rst_pwm", 32'(pwm_out), 32'd0);
    chk("rst_pwm2", 32'(pwm2), 32'd0);
    repeat (n - 1) step();
    chk("rst_cnt", 32'(counter), 32'd0);
    chk("rst_pos", pos, 32'd0);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    chk("rst_dout", 32'(data_out), 32'd0);
    chk("rst_pos2", 32'(pos2), 32'd0);
    chk("rst_dout2", 32'(dout2), 32'd0);
    sbq.delete();
    mpos    = '{0, 0, 0, 0};
    cur     = '{0, 0, 0, 0};
    ctr_m   = 0;
    seen    = 0;
    bnd     = 0;
    last_d  = '0;
    last_d2 = '0;
    rst_n   = 1'b1;
    mon_en  = 1;
    mon();
  endtask

  task automatic run_frame(input logic [3:0] tg, input logic [3:0] fz,
                           input logic [1:0] s, input bit glitch);
    exp_t e;
    int   c;
    int   c2;
    wait_c(HALF);
    toggle = tg;
    freeze = fz;
    sel    = s;
    for (int i = 0; i < 4; i++) begin
      if (!fz[i]) begin
        if (tg[i] && mpos[i] < K) mpos[i]++;
        else if (!tg[i] && mpos[i] > 0) mpos[i]--;
      end
    end
    c  = (int'(s) < 4) ? int'(s) : 0;
    c2 = (int'(s) < 2) ? int'(s) : 0;
    for (int i = 0; i < 4; i++) e.p[8*i +: 8] = 8'(mpos[i]);
    e.d  = stat(c, tg, fz);
    e.d2 = stat(c2, tg, fz);
    sbq.push_back(e);
    if (glitch) begin
      wait_c(HALF + 10);
      toggle[0] = 1'b1;
      wait_c(HALF + 50);
      toggle[0] = tg[0];
    end
    wait_c(1);
  endtask

  initial begin
    do_reset(5);
    run_frame(4'b0000, 4'b0000, 2'd0, 0);
    run_frame(4'b0000, 4'b0000, 2'd0, 1);
    chk("window", 32'(pos[7:0]), 32'd0);
    run_frame(4'b0000, 4'b0000, 2'd1, 0);

    for (int f = 0; f < 125; f++) begin
      run_frame(4'b0111, {1'b0, f >= 60, f >= 50, 1'b0}, 2'd2, 0);
      if (f == 0) chk("up1", 32'(pos[7:0]), 32'd1);
      if (f == 119) chk("up120", 32'(pos[7:0]), 32'(K));
      if (f == 124) chk("sat", 32'(pos[7:0]), 32'(K));
`ifdef SERVO_BANK_STATUS_EN
      if (f == 70) chk("status", 32'(data_out), 32'h6333);
`endif
    end

    for (int f = 0; f < 57; f++)
      run_frame(4'b0001, 4'b1010, 2'd1, 0);
    chk("ch2_at3", 32'(pos[23:16]), 32'd3);

    for (int f = 0; f < 5; f++)
      run_frame(4'b1000, 4'b0010, 2'd3, 0);
    chk("mix_ch0", 32'(pos[7:0]), 32'(K - 5));
    chk("mix_ch1", 32'(pos[15:8]), 32'd50);
    chk("mix_ch2", 32'(pos[23:16]), 32'd0);
    chk("mix_ch3", 32'(pos[31:24]), 32'd5);

    wait_c(100);
    chk("pre_rst_pwm", 32'(pwm_out[0]), 32'd1);
    do_reset(5);
    run_frame(4'b1111, 4'b0000, 2'd0, 0);
    run_frame(4'b1111, 4'b0000, 2'd3, 0);
    wait_c(FT - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
